serial_adder: RTL and testbench

Multi-cycle, parametrised adder built from a DIGIT-bit full-adder slice iterated over a WIDTH-bit operand pair. It is the sequential successor to the single-bit half/full adder cells. It trades latency for area: WIDTH/DIGIT cycles per add. It sits between an operand-issuing controller and a result consumer, using a start/busy/done handshake.

---
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle between the issuing controller and the serial adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: a DIGIT-bit adder slice iterated WIDTH/DIGIT times per add.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic           clk,
  input  logic           reset,
  serial_adder_if.slave  bus
);
  localparam int unsigned N  = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW = DIGIT + 1;

  // Reject parameter combinations the slice cannot tile.
  if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $fatal(1, "serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [WIDTH-1:0]  work;
  logic [WIDTH-1:0]  work_next;
  logic              carry;
  logic [CW-1:0]     count;
  logic [31:0]       idx;
  logic [DIGIT-1:0]  a_dig;
  logic [DIGIT-1:0]  b_dig;
  logic [DIGIT:0]    digit_sum;
  logic              accept;
  logic              last;

  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  sum_q;
  logic              carry_out_q;
  logic              overflow_q;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, start acceptance and the current digit's slice sum.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    idx        = 32'(count) * DIGIT;
    a_dig      = a_reg[idx +: DIGIT];
    b_dig      = b_reg[idx +: DIGIT];
    digit_sum  = {1'b0, a_dig} + {1'b0, b_dig} + DW'(carry);
    work_next  = work;
    work_next[idx +: DIGIT] = digit_sum[DIGIT-1:0];
    last       = (count == CW'(N - 1));
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, digit iteration and result publication.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      work        <= '0;
      carry       <= 1'b0;
      count       <= '0;
    end else begin
      busy_q <= (state_next == RUN);
      done_q <= (state_next == DONE);
      if (accept) begin
        a_reg <= bus.a;
        b_reg <= bus.b;
        carry <= bus.carry_in;
        work  <= '0;
        count <= '0;
      end else if (state == RUN) begin
        work  <= work_next;
        carry <= digit_sum[DIGIT];
        count <= last ? '0 : count + CW'(1);
        if (last) begin
          sum_q       <= work_next;
          carry_out_q <= digit_sum[DIGIT];
          // a^b^s at the MSB recovers the carry into the MSB.
          overflow_q  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ work_next[WIDTH-1] ^ digit_sum[DIGIT];
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder over four WIDTH/DIGIT configurations.
module tb_serial_adder;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  logic [9:0] last_res [4];

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) i81 ();
  serial_adder_if #(.WIDTH(8)) i84 ();
  serial_adder_if #(.WIDTH(8)) i88 ();
  serial_adder_if #(.WIDTH(4)) i42 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) u81 (.clk(clk), .reset(reset), .bus(i81));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u84 (.clk(clk), .reset(reset), .bus(i84));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u88 (.clk(clk), .reset(reset), .bus(i88));
  serial_adder #(.WIDTH(4), .DIGIT(2)) u42 (.clk(clk), .reset(reset), .bus(i42));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic drive(input int d, input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic ci);
    case (d)
      0: begin i81.start = st; i81.a = a; i81.b = b; i81.carry_in = ci; end
      1: begin i84.start = st; i84.a = a; i84.b = b; i84.carry_in = ci; end
      2: begin i88.start = st; i88.a = a; i88.b = b; i88.carry_in = ci; end
      default: begin i42.start = st; i42.a = a[3:0]; i42.b = b[3:0]; i42.carry_in = ci; end
    endcase
  endtask

  // {busy, done, overflow, carry_out, sum[7:0]}
  function automatic logic [11:0] obs(input int d);
    case (d)
      0: return {i81.busy, i81.done, i81.overflow, i81.carry_out, i81.sum};
      1: return {i84.busy, i84.done, i84.overflow, i84.carry_out, i84.sum};
      2: return {i88.busy, i88.done, i88.overflow, i88.carry_out, i88.sum};
      default: return {i42.busy, i42.done, i42.overflow, i42.carry_out, 4'h0, i42.sum};
    endcase
  endfunction

  // Reference: integer sum and signed range test; returns {overflow, carry_out, sum[7:0]}.
  function automatic logic [9:0] model(input int d, input logic [7:0] a, input logic [7:0] b,
                                       input logic ci);
    int w, full, sa, sb, s;
    logic [9:0] r;
    w    = (d == 3) ? 4 : 8;
    sa   = int'(a) & ((1 << w) - 1);
    sb   = int'(b) & ((1 << w) - 1);
    full = sa + sb + int'(ci);
    if (sa >= (1 << (w - 1))) sa -= (1 << w);
    if (sb >= (1 << (w - 1))) sb -= (1 << w);
    s = sa + sb + int'(ci);
    r      = '0;
    r[7:0] = 8'(full & ((1 << w) - 1));
    r[8]   = ((full >> w) & 1) != 0;
    r[9]   = (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
    return r;
  endfunction

  // Present start for one edge, then scramble the operands to prove they were captured.
  task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input string tag);
    logic [11:0] o;
    drive(d, 1'b1, a, b, ci);
    tick();
    o = obs(d);
    check({tag, "_acc_busy_done"}, 32'(o[11:10]), 32'(2'b10));
    drive(d, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  // Wait for done within a bound, checking busy and result stability while running.
  task automatic wait_result(input int d, input logic [7:0] a, input logic [7:0] b, input logic ci,
                             input int n, input bit noise, input string tag);
    logic [11:0] o;
    logic [9:0]  e;
    int          lat;
    bit          seen;
    e    = model(d, a, b, ci);
    lat  = 1;
    seen = 1'b0;
    o    = obs(d);
    for (int i = 0; i < n + 4 && !seen; i++) begin
      if (i > 0) begin
        check({tag, "_run_busy"}, 32'(o[11]), 32'(1));
        check({tag, "_hold"}, 32'(o[9:0]), 32'(last_res[d]));
        if (noise) drive(d, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      end
      tick();
      o = obs(d);
      if (o[10]) seen = 1'b1;
      else lat++;
    end
    drive(d, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    check({tag, "_latency"}, 32'(lat), 32'(n));
    check({tag, "_done_busy"}, 32'(o[11:10]), 32'(2'b01));
    check({tag, "_result"}, 32'(o[9:0]), 32'(e));
    last_res[d] = e;
  endtask

  // One cycle after done: pulse must have ended and the result must hold.
  task automatic idle_check(input int d, input string tag);
    logic [11:0] o;
    tick();
    o = obs(d);
    check({tag, "_idle_busy_done"}, 32'(o[11:10]), 32'(2'b00));
    check({tag, "_idle_hold"}, 32'(o[9:0]), 32'(last_res[d]));
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic        rc;
    logic [11:0] o;
    bit          spurious;
    int          d;
    int          nd [3];
    nd[0] = 8; nd[1] = 2; nd[2] = 1;
    for (int i = 0; i < 4; i++) begin
      drive(i, 1'b0, 8'h00, 8'h00, 1'b0);
      last_res[i] = '0;
    end

    // Reset, with start held high to show reset dominates.
    reset = 1'b1;
    drive(0, 1'b1, 8'h11, 8'h22, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) check($sformatf("reset_dut%0d", i), 32'(obs(i)), 32'(0));

    // Basic add with signed overflow.
    issue(0, 8'h5A, 8'h3C, 1'b0, "t1");
    wait_result(0, 8'h5A, 8'h3C, 1'b0, 8, 1'b0, "t1");
    idle_check(0, "t1");

    // Carry-out, then back-to-back issue in the done cycle.
    issue(0, 8'hFF, 8'h01, 1'b0, "t2a");
    wait_result(0, 8'hFF, 8'h01, 1'b0, 8, 1'b0, "t2a");
    issue(0, 8'hFF, 8'hFF, 1'b1, "t2b");
    wait_result(0, 8'hFF, 8'hFF, 1'b1, 8, 1'b0, "t2b");
    idle_check(0, "t2b");

    // Start and operand changes while busy are ignored.
    issue(0, 8'h10, 8'h20, 1'b0, "t3");
    wait_result(0, 8'h10, 8'h20, 1'b0, 8, 1'b1, "t3");
    idle_check(0, "t3");

    // Reset mid-run aborts the add and clears the result.
    issue(0, 8'h77, 8'h66, 1'b1, "t4");
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_after_reset", 32'(obs(0)), 32'(0));
    for (int i = 0; i < 4; i++) last_res[i] = '0;
    spurious = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      o = obs(0);
      if (o[11] || o[10] || o[9:0] != 10'd0) spurious = 1'b1;
    end
    check("t4_quiet_after_reset", 32'(spurious), 32'(0));
    issue(0, 8'h01, 8'h01, 1'b0, "t4b");
    wait_result(0, 8'h01, 8'h01, 1'b0, 8, 1'b0, "t4b");
    idle_check(0, "t4b");

    // Wider digits: fewer cycles, same arithmetic.
    issue(1, 8'h80, 8'h80, 1'b0, "t5_d4");
    wait_result(1, 8'h80, 8'h80, 1'b0, 2, 1'b0, "t5_d4");
    idle_check(1, "t5_d4");
    issue(2, 8'h80, 8'h80, 1'b0, "t5_d8");
    wait_result(2, 8'h80, 8'h80, 1'b0, 1, 1'b0, "t5_d8");
    idle_check(2, "t5_d8");

    // Randomized adds across the 8-bit configurations, mixing gaps and back-to-back.
    for (int i = 0; i < 60; i++) begin
      d  = int'($urandom_range(2, 0));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      issue(d, ra, rb, rc, $sformatf("rnd%0d", i));
      wait_result(d, ra, rb, rc, nd[d], 1'($urandom), $sformatf("rnd%0d", i));
      if ($urandom_range(1, 0) == 0) idle_check(d, $sformatf("rnd%0d", i));
    end

    // Exhaustive WIDTH=4, DIGIT=2, issued back-to-back.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          issue(3, 8'(a), 8'(b), 1'(c), $sformatf("ex_%0d_%0d_%0d", a, b, c));
          wait_result(3, 8'(a), 8'(b), 1'(c), 2, 1'b0, $sformatf("ex_%0d_%0d_%0d", a, b, c));
        end
      end
    end
    idle_check(3, "ex_end");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
